// File: rtl/hdc_text_classifier.sv
// rtl/hdc_text_classifier.sv - HDC trigram text classifier (ham/spam) with Hamming-distance prototype match
module hdc_text_classifier #(
  parameter int D = 256,
  parameter int MAXLEN = 160,
  parameter int CHARW = 32,
  parameter logic [D-1:0] ITEM_SEED =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             proto_we,
  input  logic             proto_sel,
  input  logic [D-1:0]     proto_data,
  input  logic             start,
  input  logic [7:0]       input_length,
  input  logic             input_label,
  input  logic             char_valid,
  input  logic [CHARW-1:0] char_data,
  output logic             busy,
  output logic             done,
  output logic             output_classification,
  output logic             correct,
  output logic [8:0]       dist_ham,
  output logic [8:0]       dist_spam
);

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, CLASSIFY} state_t;

  localparam logic [7:0] MAXLEN8 = 8'(MAXLEN);

  state_t         state_q, state_d;
  logic [D-1:0]   proto_ham, proto_spam;
  logic [7:0]     cnt_q [D];
  logic [7:0]     n_q;
  logic [7:0]     idx_q;
  logic [7:0]     len_q;
  logic           label_q;
  logic [7:0]     c_p1, c_p2;
  logic [D-1:0]   query_q, query_d;
  logic [D-1:0]   trigram;
  logic [7:0]     c_cur;
  logic [7:0]     len_start;
  logic           accept, last_char, in_classify;
  logic [8:0]     dist_ham_c, dist_spam_c, dist_ham_q, dist_spam_q;
  logic           cls_c, correct_c, cls_q, correct_q;
  logic           unused_char_hi;

  // Rotate left by amt modulo D; item vectors are rotations of the seed.
  function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int unsigned amt);
    logic [2*D-1:0] dbl;
    dbl = {v, v} << (amt % D);
    return dbl[2*D-1:D];
  endfunction

  function automatic logic [8:0] popcount(input logic [D-1:0] v);
    logic [8:0] s;
    s = '0;
    for (int i = 0; i < D; i++) s = s + {8'd0, v[i]};
    return s;
  endfunction

  assign c_cur          = char_data[7:0];
  assign unused_char_hi = ^char_data[CHARW-1:8];
  assign len_start      = (input_length > MAXLEN8) ? MAXLEN8 : input_length;
  assign accept         = (state_q == ACCUM) && char_valid;
  assign last_char      = accept && (idx_q == len_q - 8'd1);
  assign in_classify    = (state_q == CLASSIFY);

  // rotl(item(c),k) == item(c+k), so the position shifts fold into the seed rotation.
  assign trigram = rotl(ITEM_SEED, {24'd0, c_cur})
                 ^ rotl(ITEM_SEED, {24'd0, c_p1} + 32'd1)
                 ^ rotl(ITEM_SEED, {24'd0, c_p2} + 32'd2);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (len_start == 8'd0) ? THRESH : ACCUM;
      ACCUM:    if (last_char) state_d = THRESH;
      THRESH:   state_d = CLASSIFY;
      CLASSIFY: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Prototype storage, writable in any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_ham  <= '0;
      proto_spam <= '0;
    end else if (proto_we) begin
      if (proto_sel) proto_spam <= proto_data;
      else           proto_ham  <= proto_data;
    end
  end

  // Message latch, character history and trigram bundling counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) cnt_q[i] <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      label_q <= 1'b0;
      c_p1    <= '0;
      c_p2    <= '0;
      query_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q   <= len_start;
        label_q <= input_label;
        idx_q   <= '0;
        n_q     <= '0;
        for (int i = 0; i < D; i++) cnt_q[i] <= '0;
      end else if (accept) begin
        idx_q <= idx_q + 8'd1;
        c_p1  <= c_cur;
        c_p2  <= c_p1;
        if (idx_q >= 8'd2) begin
          for (int i = 0; i < D; i++)
            if (trigram[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
          n_q <= n_q + 8'd1;
        end
      end
      if (state_q == THRESH) query_q <= query_d;
    end
  end

  // Majority threshold; ties and an empty bundle give 0.
  always_comb begin
    query_d = '0;
    for (int i = 0; i < D; i++) query_d[i] = ({cnt_q[i], 1'b0} > {1'b0, n_q});
  end

  // Distances and decision from the registered query; ties go to ham.
  always_comb begin
    dist_ham_c  = popcount(query_q ^ proto_ham);
    dist_spam_c = popcount(query_q ^ proto_spam);
    cls_c       = (dist_spam_c < dist_ham_c);
    correct_c   = (cls_c == label_q);
  end

  // Hold the last result between classifications.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dist_ham_q  <= '0;
      dist_spam_q <= '0;
      cls_q       <= 1'b0;
      correct_q   <= 1'b0;
    end else if (in_classify) begin
      dist_ham_q  <= dist_ham_c;
      dist_spam_q <= dist_spam_c;
      cls_q       <= cls_c;
      correct_q   <= correct_c;
    end
  end

  assign busy                  = (state_q != IDLE);
  assign done                  = in_classify;
  assign dist_ham              = in_classify ? dist_ham_c  : dist_ham_q;
  assign dist_spam             = in_classify ? dist_spam_c : dist_spam_q;
  assign output_classification = in_classify ? cls_c       : cls_q;
  assign correct               = in_classify ? correct_c   : correct_q;

endmodule

// File: tb/tb_hdc_text_classifier.sv
// tb/tb_hdc_text_classifier.sv - directed plus randomized check of hdc_text_classifier against a reference model
module tb_hdc_text_classifier;

  localparam int D = 256;
  localparam logic [255:0] SEED =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

  logic         clk = 1'b0;
  logic         reset;
  logic         proto_we, proto_sel;
  logic [D-1:0] proto_data;
  logic         start;
  logic [7:0]   input_length;
  logic         input_label;
  logic         char_valid;
  logic [31:0]  char_data;
  logic         busy, done, output_classification, correct;
  logic [8:0]   dist_ham, dist_spam;

  int           vectors = 0;
  int           miscompares = 0;
  int           msg[$];
  logic [255:0] ham_m, spam_m;
  logic [255:0] t_aaa, rq;

  hdc_text_classifier dut (
    .clk(clk), .reset(reset),
    .proto_we(proto_we), .proto_sel(proto_sel), .proto_data(proto_data),
    .start(start), .input_length(input_length), .input_label(input_label),
    .char_valid(char_valid), .char_data(char_data),
    .busy(busy), .done(done), .output_classification(output_classification),
    .correct(correct), .dist_ham(dist_ham), .dist_spam(dist_spam)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rot_m(input logic [255:0] v, input int k);
    logic [255:0] r;
    for (int j = 0; j < 256; j++) r[(j + k) % 256] = v[j];
    return r;
  endfunction

  function automatic logic [255:0] item_m(input int c);
    return rot_m(SEED, c);
  endfunction

  function automatic logic [255:0] trigram_m(input int a, input int b, input int c);
    return item_m(c) ^ rot_m(item_m(b), 1) ^ rot_m(item_m(a), 2);
  endfunction

  // Majority vote over all trigrams of the first len characters of msg.
  function automatic logic [255:0] model_query(input int len);
    int           votes[256];
    int           n;
    logic [255:0] t, q;
    n = 0;
    for (int i = 0; i < 256; i++) votes[i] = 0;
    for (int p = 2; p < len; p++) begin
      t = trigram_m(msg[p-2], msg[p-1], msg[p]);
      n++;
      for (int i = 0; i < 256; i++) votes[i] += int'(t[i]);
    end
    for (int i = 0; i < 256; i++) q[i] = (2 * votes[i] > n);
    return q;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic make_msg(input int n, input bit letters);
    msg.delete();
    for (int i = 0; i < n; i++)
      msg.push_back(letters ? 97 + int'($urandom_range(0, 25)) : int'($urandom_range(0, 255)));
  endtask

  task automatic load_proto(input bit sel, input logic [255:0] v);
    proto_we = 1'b1; proto_sel = sel; proto_data = v;
    @(posedge clk); #1;
    proto_we = 1'b0;
    if (sel) spam_m = v; else ham_m = v;
  endtask

  // Runs one message; begins and ends 1 time unit after a rising edge.
  task automatic run_msg(input string tag, input int len_in, input bit lbl, input bit noise);
    int           acc, eh, es;
    bit           ec, ecor;
    logic [255:0] q;
    acc  = (len_in > 160) ? 160 : len_in;
    q    = model_query(acc);
    eh   = $countones(q ^ ham_m);
    es   = $countones(q ^ spam_m);
    ec   = (es < eh);
    ecor = (ec == lbl);
    start = 1'b1; input_length = 8'(len_in); input_label = lbl;
    @(negedge clk); chk({tag, ".idle_busy"}, busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < acc; i++) begin
      if (!noise && $urandom_range(0, 3) == 0) begin
        @(negedge clk); chk({tag, ".gap_busy"}, busy, 1);
        @(posedge clk); #1;
      end
      char_valid = 1'b1;
      char_data  = {24'($urandom), 8'(msg[i])};
      start      = noise;
      @(posedge clk); #1;
      char_valid = 1'b0; start = 1'b0;
    end
    if (noise) begin
      char_valid = 1'b1; char_data = $urandom; start = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".pre_done"}, done, 0);
    chk({tag, ".pre_busy"}, busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".class"}, output_classification, ec);
    chk({tag, ".correct"}, correct, ecor);
    chk({tag, ".dist_ham"}, dist_ham, eh);
    chk({tag, ".dist_spam"}, dist_spam, es);
    @(posedge clk); #1;
    char_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".post_done"}, done, 0);
    chk({tag, ".post_busy"}, busy, 0);
    chk({tag, ".hold_class"}, output_classification, ec);
    chk({tag, ".hold_ham"}, dist_ham, eh);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; proto_we = 1'b0; proto_sel = 1'b0; proto_data = '0;
    start = 1'b0; input_length = '0; input_label = 1'b0;
    char_valid = 1'b0; char_data = '0;
    ham_m = '0; spam_m = '0;

    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.class", output_classification, 0);
    chk("rst.correct", correct, 0);
    chk("rst.dist_ham", dist_ham, 0);
    chk("rst.dist_spam", dist_spam, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    msg.delete();
    run_msg("len0", 0, 1'b0, 1'b0);

    load_proto(1'b0, '0);
    load_proto(1'b1, '1);
    msg.delete(); msg.push_back(97); msg.push_back(98);
    run_msg("ab", 2, 1'b1, 1'b0);

    t_aaa = trigram_m(97, 97, 97);
    load_proto(1'b0, t_aaa);
    load_proto(1'b1, ~t_aaa);
    msg.delete(); repeat (4) msg.push_back(97);
    run_msg("aaaa_ham", 4, 1'b0, 1'b0);
    chk("aaaa_ham.dist_spam_256", dist_spam, 256);

    load_proto(1'b0, ~t_aaa);
    load_proto(1'b1, t_aaa);
    run_msg("aaaa_spam", 4, 1'b1, 1'b0);
    chk("aaaa_spam.class1", output_classification, 1);

    for (int k = 0; k < 6; k++) begin
      make_msg($urandom_range(0, 40), k[0]);
      load_proto(1'b0, rand256());
      rq = model_query(msg.size());
      load_proto(1'b1, (k % 3 == 0) ? (rq ^ (rand256() & rand256() & rand256())) : rand256());
      run_msg("rand", msg.size(), 1'($urandom_range(0, 1)), 1'b0);
    end

    make_msg(200, 1'b0);
    load_proto(1'b0, rand256());
    rq = model_query(160);
    load_proto(1'b1, rq ^ (rand256() & rand256()));
    run_msg("len200", 200, 1'b1, 1'b1);

    make_msg(10, 1'b1);
    start = 1'b1; input_length = 8'd10; input_label = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      char_valid = 1'b1; char_data = {24'd0, 8'(msg[i])};
      @(posedge clk); #1;
    end
    char_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.dist_ham", dist_ham, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    ham_m = '0; spam_m = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.no_done", done, 0);
    end
    @(posedge clk); #1;
    make_msg(12, 1'b1);
    rq = model_query(12);
    load_proto(1'b0, rand256());
    load_proto(1'b1, rq);
    run_msg("fresh", 12, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
